// File: rtl/mmu_mem_arbiter.sv
// Shares the single memory port between the PTW, data and fetch requesters.
// One transaction in flight; fixed priority PTW > data > inst with a fetch starvation guard.
module mmu_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ptw_req,
    input  logic        d_req,
    input  logic        i_req,
    input  logic [63:0] ptw_addr,
    input  logic [63:0] d_addr,
    input  logic [63:0] i_addr,
    input  logic        d_we,
    input  logic [63:0] d_wdata,
    input  logic [2:0]  d_width,
    output logic        ptw_gnt,
    output logic        d_gnt,
    output logic        i_gnt,
    output logic        ptw_rvalid,
    output logic        d_rvalid,
    output logic        i_rvalid,
    output logic [63:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [2:0]  mem_width,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PTW  = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_I    = 2'd3;
    localparam logic [3:0] SL       = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  mem_width_q, mem_width_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  rvalid_q, rvalid_d;  // {inst, data, ptw}
    logic [1:0]  win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_width_d = mem_width_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        rvalid_d    = 3'b000;
        win         = OWN_NONE;

        case (state_q)
            IDLE: begin
                if (ptw_req)                      win = OWN_PTW;
                else if (i_req && starve_q == SL) win = OWN_I;
                else if (d_req)                   win = OWN_D;
                else if (i_req)                   win = OWN_I;

                if (win != OWN_NONE) begin
                    state_d     = BUSY;
                    mem_req_d   = 1'b1;
                    owner_d     = win;
                    tmo_d       = 8'd0;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 64'd0;
                    case (win)
                        OWN_PTW: begin
                            mem_addr_d  = ptw_addr;
                            mem_width_d = 3'b011;
                        end
                        OWN_D: begin
                            mem_addr_d  = d_addr;
                            mem_width_d = d_width;
                            mem_we_d    = d_we;
                            mem_wdata_d = d_wdata;
                        end
                        default: begin
                            mem_addr_d  = i_addr;
                            mem_width_d = 3'b010;
                        end
                    endcase
                    // Fetch losing an arbitration it was present for counts towards the guard.
                    if (win == OWN_I)
                        starve_d = 4'd0;
                    else if (i_req && starve_q < SL)
                        starve_d = starve_q + 4'd1;
                end
            end
            BUSY: begin
                if (mem_ack || tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    rdata_d   = mem_ack ? mem_rdata : 64'd0;
                    err_d     = ~mem_ack;
                    case (owner_q)
                        OWN_PTW: rvalid_d = 3'b001;
                        OWN_D:   rvalid_d = 3'b010;
                        OWN_I:   rvalid_d = 3'b100;
                        default: rvalid_d = 3'b000;
                    endcase
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Grants are combinational, so mask them while reset is held.
        ptw_gnt = ~rst & (win == OWN_PTW);
        d_gnt   = ~rst & (win == OWN_D);
        i_gnt   = ~rst & (win == OWN_I);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= 4'd0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 64'd0;
            mem_wdata_q <= 64'd0;
            mem_width_q <= 3'd0;
            rdata_q     <= 64'd0;
            err_q       <= 1'b0;
            rvalid_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_width_q <= mem_width_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign busy       = (state_q == BUSY);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_width  = mem_width_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign ptw_rvalid = rvalid_q[0];
    assign d_rvalid   = rvalid_q[1];
    assign i_rvalid   = rvalid_q[2];

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed + randomized bench for mmu_mem_arbiter against a cycle-level behavioural model.
module tb_mmu_mem_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptw_req = 0, d_req = 0, i_req = 0;
    logic [63:0] ptw_addr = 0, d_addr = 0, i_addr = 0;
    logic        d_we = 0;
    logic [63:0] d_wdata = 0;
    logic [2:0]  d_width = 0;
    logic        ptw_gnt, d_gnt, i_gnt;
    logic        ptw_rvalid, d_rvalid, i_rvalid;
    logic [63:0] rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [2:0]  mem_width;
    logic        mem_ack = 0;
    logic [63:0] mem_rdata = 0;
    logic        busy;

    mmu_mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ptw_req(ptw_req), .d_req(d_req), .i_req(i_req),
        .ptw_addr(ptw_addr), .d_addr(d_addr), .i_addr(i_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_width(d_width),
        .ptw_gnt(ptw_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
        .ptw_rvalid(ptw_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid),
        .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: owner 0 none, 1 ptw, 2 data, 3 inst.
    bit          m_busy;
    int          m_own, m_gcyc, m_starve;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        m_we, m_err;
    logic [2:0]  m_width;
    logic [3:1]  m_rv;

    int          cyc = 0;
    int          ack_lat = 1;
    bit          rnd_lat = 0;
    logic        idle_ack = 0;
    int          obs_gnt[$];
    int          last_gnt_cyc = 0, last_rv_cyc = 0, last_rv_own = 0;
    logic        last_err = 0;
    logic [63:0] last_rdata = 0, ack_data = 0;
    int          rv_cnt[4];
    int          rv_save[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_gcyc = 0; m_starve = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0;
        m_we = 0; m_err = 0; m_width = 0; m_rv = '0;
    endtask

    function automatic int winner();
        if (m_busy || rst) return 0;
        if (ptw_req) return 1;
        if (i_req && m_starve == SL) return 3;
        if (d_req) return 2;
        if (i_req) return 3;
        return 0;
    endfunction

    task automatic check_outputs(input int w);
        chk("ptw_gnt", ptw_gnt, w == 1);
        chk("d_gnt", d_gnt, w == 2);
        chk("i_gnt", i_gnt, w == 3);
        chk("mem_req", mem_req, m_busy);
        chk("busy", busy, m_busy);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", mem_we, m_we);
        chk("mem_width", mem_width, m_width);
        if (m_own == 2) chk("mem_wdata", mem_wdata, m_wdata);
        chk("ptw_rvalid", ptw_rvalid, m_rv[1]);
        chk("d_rvalid", d_rvalid, m_rv[2]);
        chk("i_rvalid", i_rvalid, m_rv[3]);
        chk("err", err, m_err);
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic cycle();
        int w;
        mem_rdata = {$urandom(), $urandom()};
        if (m_busy) mem_ack = (ack_lat >= 0) && (cyc - m_gcyc - 1 == ack_lat);
        else        mem_ack = idle_ack;
        if (m_busy && mem_ack) ack_data = mem_rdata;
        w = winner();
        @(negedge clk);
        check_outputs(w);
        if (ptw_gnt) obs_gnt.push_back(1);
        if (d_gnt)   obs_gnt.push_back(2);
        if (i_gnt)   obs_gnt.push_back(3);
        if (ptw_gnt || d_gnt || i_gnt) last_gnt_cyc = cyc;
        if (ptw_rvalid || d_rvalid || i_rvalid) begin
            last_rv_cyc = cyc; last_err = err; last_rdata = rdata;
            if (ptw_rvalid) begin rv_cnt[1]++; last_rv_own = 1; end
            if (d_rvalid)   begin rv_cnt[2]++; last_rv_own = 2; end
            if (i_rvalid)   begin rv_cnt[3]++; last_rv_own = 3; end
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_rv = '0; m_err = 0;
            if (w != 0) begin
                m_busy = 1; m_own = w; m_gcyc = cyc; m_we = 0; m_wdata = 0;
                case (w)
                    1: begin m_addr = ptw_addr; m_width = 3'b011; end
                    2: begin m_addr = d_addr; m_width = d_width; m_we = d_we; m_wdata = d_wdata; end
                    default: begin m_addr = i_addr; m_width = 3'b010; end
                endcase
                if (w == 3) m_starve = 0;
                else if (i_req) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                if (rnd_lat) ack_lat = $urandom_range(0, 9);
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_rv[m_own] = 1'b1; m_rdata = mem_rdata; m_busy = 0;
                end else if (cyc == m_gcyc + TO) begin
                    m_rv[m_own] = 1'b1; m_rdata = 0; m_err = 1; m_busy = 0;
                end
            end
        end
        cyc++;
        #1;
        if (w == 1) ptw_req = 0;
        if (w == 2) d_req = 0;
        if (w == 3) i_req = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_busy || ptw_req || d_req || i_req) && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_bound", n < 100, 1);
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (rv_cnt[k]) rv_cnt[k] = 0;
        #1;
        model_reset();
        check_outputs(0);
        chk("reset_wdata", mem_wdata, 0);
        cycle();
        cycle();
        rst = 0;

        // single instruction read
        ack_lat = 2;
        i_addr = 64'h80200000;
        i_req = 1;
        drain();
        chk("inst_owner", last_rv_own, 3);
        chk("inst_latency", last_rv_cyc - last_gnt_cyc, 4);
        chk("inst_rdata", last_rdata, ack_data);
        chk("inst_rvcnt", rv_cnt[3], 1);
        chk("inst_addr", mem_addr, 64'h80200000);

        // priority with all three pending
        obs_gnt.delete();
        rv_save = rv_cnt;
        ack_lat = 1;
        ptw_addr = {$urandom(), $urandom()};
        d_addr = {$urandom(), $urandom()};
        i_addr = {$urandom(), $urandom()};
        d_width = 3'b001;
        ptw_req = 1; d_req = 1; i_req = 1;
        drain();
        chk("prio_count", obs_gnt.size(), 3);
        chk("prio_0", obs_gnt[0], 1);
        chk("prio_1", obs_gnt[1], 2);
        chk("prio_2", obs_gnt[2], 3);
        chk("prio_rv_ptw", rv_cnt[1] - rv_save[1], 1);
        chk("prio_rv_d", rv_cnt[2] - rv_save[2], 1);
        chk("prio_rv_i", rv_cnt[3] - rv_save[3], 1);

        // starvation guard
        obs_gnt.delete();
        ack_lat = 0;
        d_req = 1; i_req = 1;
        for (int n = 0; n < 80 && obs_gnt.size() < 6; n++) begin
            cycle();
            if (obs_gnt.size() < 6) begin d_req = 1; i_req = 1; end
        end
        drain();
        chk("starve_count", obs_gnt.size() >= 6, 1);
        chk("starve_g0", obs_gnt[0], 2);
        chk("starve_g3", obs_gnt[3], 2);
        chk("starve_g4", obs_gnt[4], 3);
        chk("starve_g5", obs_gnt[5], 2);

        // data write
        rv_save = rv_cnt;
        ack_lat = 3;
        d_we = 1; d_wdata = 64'hdeadbeefcafef00d; d_width = 3'b011;
        d_addr = {$urandom(), $urandom()};
        d_req = 1;
        drain();
        d_we = 0;
        chk("wr_wdata", mem_wdata, 64'hdeadbeefcafef00d);
        chk("wr_we", mem_we, 1);
        chk("wr_rv_d", rv_cnt[2] - rv_save[2], 1);
        chk("wr_rv_ptw", rv_cnt[1] - rv_save[1], 0);
        chk("wr_rv_i", rv_cnt[3] - rv_save[3], 0);

        // timeout with no ack
        ack_lat = -1;
        ptw_addr = {$urandom(), $urandom()};
        ptw_req = 1;
        drain();
        chk("to_latency", last_rv_cyc - last_gnt_cyc, TO + 1);
        chk("to_owner", last_rv_own, 1);
        chk("to_err", last_err, 1);
        chk("to_rdata", last_rdata, 0);

        // reset one cycle after a grant
        rv_save = rv_cnt;
        d_addr = {$urandom(), $urandom()};
        d_req = 1;
        cycle();
        cycle();
        rst = 1;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        model_reset();
        i_addr = {$urandom(), $urandom()};
        i_req = 1;
        idle_ack = 1;
        cycle();
        cycle();
        rst = 0;
        idle_ack = 0;
        ack_lat = 1;
        drain();
        chk("rst_rv_d", rv_cnt[2] - rv_save[2], 0);
        chk("rst_rv_i", rv_cnt[3] - rv_save[3], 1);

        // randomized traffic
        rnd_lat = 1;
        for (int n = 0; n < 400; n++) begin
            cycle();
            idle_ack = ($urandom_range(0, 4) == 0);
            if (!ptw_req && $urandom_range(0, 3) == 0) begin
                ptw_req = 1; ptw_addr = {$urandom(), $urandom()};
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = {$urandom(), $urandom()};
                d_we = $urandom_range(0, 1); d_wdata = {$urandom(), $urandom()};
                d_width = 3'($urandom_range(0, 7));
            end
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_addr = {$urandom(), $urandom()};
            end
        end
        idle_ack = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
